real_to_float32: RTL and testbench

REAL_TO_FLOAT32 -- requirements
Module: real_to_float32

---
 rtl/svreal_float_pkg.sv | 17 +
 rtl/real_to_float32_round_nearest_even.sv | 40 ++++
 rtl/real_to_float32.sv | 138 +++++++++++++
 tb/tb_real_to_float32.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svreal_float_pkg.sv
// Shared definitions for the fixed-point to IEEE-754 binary32 converter:
// FSM state encoding and binary32 field constants.
package svreal_float_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_PACK = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int          F32_BIAS     = 127;
    localparam int          F32_MANT_W   = 23;
    localparam int          F32_EXP_ONES = 255;
    localparam logic [31:0] F32_POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/real_to_float32_round_nearest_even.sv
// Combinational mantissa rounding: takes the fraction bits below the
// leading one and produces a 23-bit binary32 mantissa, rounded to nearest
// with ties to even when the fraction is wider than 23 bits.
module round_nearest_even
    import svreal_float_pkg::*;
#(
    parameter int IN_W = 18
) (
    input  logic [IN_W-1:0]       frac,
    output logic [F32_MANT_W-1:0] mant,
    output logic                  carry
);

    generate
        if (IN_W <= F32_MANT_W) begin : g_pad
            // Narrow fractions fit exactly: left-align and zero-pad.
            assign mant  = F32_MANT_W'(frac) << (F32_MANT_W - IN_W);
            assign carry = 1'b0;
        end else begin : g_round
            logic [F32_MANT_W-1:0] top;
            logic                  guard;
            logic                  sticky;
            logic                  round_up;

            assign top   = frac[IN_W-1 -: F32_MANT_W];
            assign guard = frac[IN_W-F32_MANT_W-1];

            if (IN_W > F32_MANT_W + 1) begin : g_sticky
                assign sticky = |frac[IN_W-F32_MANT_W-2:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end

            // Exact halfway rounds up only when that makes the mantissa even.
            assign round_up      = guard & (sticky | top[0]);
            assign {carry, mant} = {1'b0, top} + {{F32_MANT_W{1'b0}}, round_up};
        end
    endgenerate

endmodule

// File: rtl/real_to_float32.sv
// Converts a signed fixed-point value (in * 2^EXPONENT) into an IEEE-754
// binary32 word. The magnitude is normalised one bit per cycle, then packed
// with rounding, overflow to infinity and flush-to-zero on underflow.
module real_to_float32
    import svreal_float_pkg::*;
#(
    parameter int WIDTH    = 18,
    parameter int EXPONENT = -16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [31:0]             out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int S_W   = $clog2(WIDTH + 2);
    // Wide enough that WIDTH + EXPONENT + bias + carry never wraps.
    localparam int EXP_W = 34;

    localparam logic signed [EXP_W-1:0] EXP_CONST =
        EXP_W'(EXPONENT) + EXP_W'(WIDTH + F32_BIAS);
    localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(F32_EXP_ONES);
    localparam logic signed [EXP_W-1:0] E_ZERO = '0;

    state_t state, state_next;

    logic                  sign_r;
    logic [WIDTH:0]        mag;
    logic [S_W-1:0]        s;

    logic signed [WIDTH:0] in_ext;
    logic [WIDTH:0]        in_abs;
    logic                  in_zero;

    logic [F32_MANT_W-1:0] rnd_mant;
    logic                  rnd_carry;
    logic signed [EXP_W-1:0] e_pre;
    logic signed [EXP_W-1:0] e_rnd;

    // Final field assembly with overflow/underflow saturation.
    function automatic logic [31:0] pack_result(
        input logic                    sgn,
        input logic                    nonzero,
        input logic signed [EXP_W-1:0] e,
        input logic [F32_MANT_W-1:0]   m
    );
        logic [31:0] r;
        if (!nonzero || e <= E_ZERO) begin
            r = '0;
        end else if (e >= E_MAX) begin
            r = F32_POS_INF | {sgn, 31'b0};
        end else begin
            r = {sgn, e[7:0], m};
        end
        return r;
    endfunction

    // The extra magnitude bit makes |most-negative| representable exactly.
    assign in_ext  = {in[WIDTH-1], in};
    assign in_abs  = in_ext[WIDTH] ? -in_ext : in_ext;
    assign in_zero = (in == '0);

    round_nearest_even #(
        .IN_W (WIDTH)
    ) u_round (
        .frac  (mag[WIDTH-1:0]),
        .mant  (rnd_mant),
        .carry (rnd_carry)
    );

    assign e_pre = EXP_CONST - $signed({{(EXP_W-S_W){1'b0}}, s});
    assign e_rnd = e_pre + $signed({{(EXP_W-1){1'b0}}, rnd_carry});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: zero skips normalisation entirely.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid) state_next = in_zero ? ST_PACK : ST_NORM;
            ST_NORM: if (mag[WIDTH]) state_next = ST_PACK;
            ST_PACK: state_next = ST_HOLD;
            ST_HOLD: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
    end

    // Datapath: capture, normalise by single-bit shifts, then pack the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r <= 1'b0;
            mag    <= '0;
            s      <= '0;
            out    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_r <= in[WIDTH-1];
                        mag    <= in_abs;
                        s      <= '0;
                    end
                end
                ST_NORM: begin
                    if (!mag[WIDTH]) begin
                        mag <= mag << 1;
                        s   <= s + S_W'(1);
                    end
                end
                ST_PACK: begin
                    // A normalised nonzero magnitude always has its top bit set.
                    out <= pack_result(sign_r, mag[WIDTH], e_rnd, rnd_mant);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_real_to_float32.sv
// Bench for real_to_float32: four instances (18/-16, 18/120, 18/-160 in
// lockstep on shared inputs, and 32/0 on its own) checked every cycle
// against a value-level binary32 model.
module tb_real_to_float32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    // Group A: three instances sharing inputs (WIDTH=18).
    logic               rst_a = 1'b1;
    logic signed [17:0] a_in  = '0;
    logic               a_vld = 1'b0;
    logic               a_ordy = 1'b0;
    logic               a_rdy, a_ovld, a_busy;
    logic [31:0]        a_out;
    logic               c_rdy, c_ovld, c_busy;
    logic [31:0]        c_out;
    logic               d_rdy, d_ovld, d_busy;
    logic [31:0]        d_out;

    // Group B: WIDTH=32, EXPONENT=0.
    logic               rst_b = 1'b1;
    logic signed [31:0] b_in  = '0;
    logic               b_vld = 1'b0;
    logic               b_ordy = 1'b0;
    logic               b_rdy, b_ovld, b_busy;
    logic [31:0]        b_out;

    bit hold_a_low = 1'b0;

    real_to_float32 #(.WIDTH(18), .EXPONENT(-16)) u_a (
        .clk(clk), .rst(rst_a), .in(a_in), .in_valid(a_vld), .in_ready(a_rdy),
        .out(a_out), .out_valid(a_ovld), .out_ready(a_ordy), .busy(a_busy));
    real_to_float32 #(.WIDTH(18), .EXPONENT(120)) u_c (
        .clk(clk), .rst(rst_a), .in(a_in), .in_valid(a_vld), .in_ready(c_rdy),
        .out(c_out), .out_valid(c_ovld), .out_ready(a_ordy), .busy(c_busy));
    real_to_float32 #(.WIDTH(18), .EXPONENT(-160)) u_d (
        .clk(clk), .rst(rst_a), .in(a_in), .in_valid(a_vld), .in_ready(d_rdy),
        .out(d_out), .out_valid(d_ovld), .out_ready(a_ordy), .busy(d_busy));
    real_to_float32 #(.WIDTH(32), .EXPONENT(0)) u_b (
        .clk(clk), .rst(rst_b), .in(b_in), .in_valid(b_vld), .in_ready(b_rdy),
        .out(b_out), .out_valid(b_ovld), .out_ready(b_ordy), .busy(b_busy));

    typedef struct {
        logic [31:0] ea;
        logic [31:0] ec;
        logic [31:0] ed;
        int          acc;
        int          due;
    } exp_a_t;
    typedef struct {
        logic [31:0] eb;
        int          acc;
        int          due;
    } exp_b_t;

    exp_a_t qa[$];
    exp_b_t qb[$];

    // Value-level reference: value = v * 2^ex rendered as binary32.
    function automatic logic [31:0] model(input longint v, input int ex);
        logic   sgn;
        longint m, frac, q, rem, half;
        int     p, e;
        sgn = (v < 0);
        m   = sgn ? -v : v;
        if (m == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 63; i++) if ((m >> i) != 0) p = i;
        e    = p + ex + 127;
        frac = m - (64'sd1 << p);
        if (p <= 23) begin
            q = frac << (23 - p);
        end else begin
            q    = frac >> (p - 23);
            rem  = frac - (q << (p - 23));
            half = 64'sd1 << (p - 24);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 << 23)) begin
                q = 0;
                e = e + 1;
            end
        end
        if (e >= 255) return {sgn, 8'hFF, 23'h0};
        if (e <= 0) return 32'h0;
        return {sgn, e[7:0], q[22:0]};
    endfunction

    // Edges from acceptance to out_valid: one per leading-zero shift plus two.
    function automatic int lat(input longint v, input int w);
        longint m;
        int     p;
        m = (v < 0) ? -v : v;
        if (m == 0) return 1;
        p = 0;
        for (int i = 0; i < 63; i++) if ((m >> i) != 0) p = i;
        return (w - p) + 2;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Group A compare: status and result on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst_a) begin
            if (qa.size() == 0 || cyc < qa[0].acc) begin
                chk1("a_idle_ovld", a_ovld, 1'b0);
                chk1("a_idle_rdy", a_rdy, 1'b1);
                chk1("a_idle_busy", a_busy, 1'b0);
                chk1("c_idle_ovld", c_ovld, 1'b0);
                chk1("d_idle_ovld", d_ovld, 1'b0);
            end else if (cyc < qa[0].due) begin
                chk1("a_work_ovld", a_ovld, 1'b0);
                chk1("a_work_rdy", a_rdy, 1'b0);
                chk1("a_work_busy", a_busy, 1'b1);
                chk1("c_work_ovld", c_ovld, 1'b0);
                chk1("d_work_ovld", d_ovld, 1'b0);
            end else begin
                chk1("a_hold_ovld", a_ovld, 1'b1);
                chk1("a_hold_rdy", a_rdy, 1'b0);
                chk1("c_hold_ovld", c_ovld, 1'b1);
                chk1("d_hold_ovld", d_ovld, 1'b1);
                chk32("a_out", a_out, qa[0].ea);
                chk32("c_out", c_out, qa[0].ec);
                chk32("d_out", d_out, qa[0].ed);
                if (a_ordy) void'(qa.pop_front());
            end
        end
    end

    // Group B compare.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (qb.size() == 0 || cyc < qb[0].acc) begin
                chk1("b_idle_ovld", b_ovld, 1'b0);
                chk1("b_idle_rdy", b_rdy, 1'b1);
                chk1("b_idle_busy", b_busy, 1'b0);
            end else if (cyc < qb[0].due) begin
                chk1("b_work_ovld", b_ovld, 1'b0);
                chk1("b_work_rdy", b_rdy, 1'b0);
            end else begin
                chk1("b_hold_ovld", b_ovld, 1'b1);
                chk32("b_out", b_out, qb[0].eb);
                if (b_ordy) void'(qb.pop_front());
            end
        end
    end

    // Consumer back-pressure: mostly ready, occasionally stalling.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            a_ordy = hold_a_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            b_ordy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_a(input longint v);
        int guard = 0;
        @(posedge clk);
        #2;
        while (!a_rdy) begin
            guard++;
            if (guard > 200) begin
                n_vec++;
                n_fail++;
                $display("FAIL a_send_timeout: in_ready stayed 0, expected 1");
                return;
            end
            @(posedge clk);
            #2;
        end
        a_in  = v[17:0];
        a_vld = 1'b1;
        qa.push_back('{ea: model(v, -16), ec: model(v, 120), ed: model(v, -160),
                       acc: cyc + 1, due: cyc + 1 + lat(v, 18)});
        @(posedge clk);
        #2;
        a_vld = 1'b0;
        a_in  = 18'($urandom);
    endtask

    task automatic send_b(input longint v);
        int guard = 0;
        @(posedge clk);
        #2;
        while (!b_rdy) begin
            guard++;
            if (guard > 200) begin
                n_vec++;
                n_fail++;
                $display("FAIL b_send_timeout: in_ready stayed 0, expected 1");
                return;
            end
            @(posedge clk);
            #2;
        end
        b_in  = v[31:0];
        b_vld = 1'b1;
        qb.push_back('{eb: model(v, 0), acc: cyc + 1, due: cyc + 1 + lat(v, 32)});
        @(posedge clk);
        #2;
        b_vld = 1'b0;
        b_in  = 32'($urandom);
    endtask

    task automatic wait_idle_a();
        int guard = 0;
        while (qa.size() != 0) begin
            guard++;
            if (guard > 300) begin
                n_vec++;
                n_fail++;
                $display("FAIL a_drain_timeout: %0d results pending, expected 0", qa.size());
                qa.delete();
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_idle_b();
        int guard = 0;
        while (qb.size() != 0) begin
            guard++;
            if (guard > 300) begin
                n_vec++;
                n_fail++;
                $display("FAIL b_drain_timeout: %0d results pending, expected 0", qb.size());
                qb.delete();
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_a();
        longint dir_a[7] = '{65536, -65536, -131072, 1, 0, 131071, -1};
        logic signed [17:0] r;
        logic [31:0] held;
        int guard;

        foreach (dir_a[i]) send_a(dir_a[i]);
        wait_idle_a();

        // Long stall in HOLD with stray in_valid pulses that must be ignored.
        hold_a_low = 1'b1;
        send_a(65536);
        guard = 0;
        while (!a_ovld && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk1("a_stall_reached_hold", a_ovld, 1'b1);
        held = a_out;
        for (int k = 0; k < 10; k++) begin
            a_vld = 1'b1;
            a_in  = 18'($urandom);
            @(posedge clk);
            #2;
            chk32("a_stall_stable", a_out, held);
            chk1("a_stall_rdy", a_rdy, 1'b0);
        end
        chk32("a_stall_value", held, 32'h3F80_0000);
        a_vld      = 1'b0;
        hold_a_low = 1'b0;
        wait_idle_a();

        // Reset in the middle of a long normalisation.
        send_a(1);
        repeat (4) @(posedge clk);
        #2;
        rst_a = 1'b1;
        qa.delete();
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        chk32("a_rst_mid_out", a_out, 32'h0);
        chk1("a_rst_mid_ovld", a_ovld, 1'b0);
        chk1("a_rst_mid_rdy", a_rdy, 1'b1);
        chk1("a_rst_mid_busy", a_busy, 1'b0);
        repeat (25) @(posedge clk);
        send_a(65536);
        wait_idle_a();
        chk32("a_after_rst_value", a_out, 32'h3F80_0000);

        for (int n = 0; n < 150; n++) begin
            r = 18'($urandom);
            send_a(longint'(r) >>> $urandom_range(0, 17));
        end
        wait_idle_a();
    endtask

    task automatic run_b();
        longint dir_b[8] = '{32'sh7FFF_FFFF, 32'sh0100_0003, -64'sd2147483648,
                             32'sh0100_0001, 32'sh0100_0005, 0, 32'sh00FF_FFFF, -1};
        logic signed [31:0] r;
        foreach (dir_b[i]) send_b(dir_b[i]);
        for (int n = 0; n < 150; n++) begin
            r = 32'($urandom);
            send_b(longint'(r) >>> $urandom_range(0, 31));
        end
        wait_idle_b();
    endtask

    initial begin
        // Hand-computed anchors for the reference model.
        chk32("pin_one", model(65536, -16), 32'h3F80_0000);
        chk32("pin_neg_one", model(-65536, -16), 32'hBF80_0000);
        chk32("pin_neg_two", model(-131072, -16), 32'hC000_0000);
        chk32("pin_lsb", model(1, -16), 32'h3780_0000);
        chk32("pin_zero", model(0, -16), 32'h0);
        chk32("pin_carry", model(32'sh7FFF_FFFF, 0), 32'h4F00_0000);
        chk32("pin_tie_even", model(32'sh0100_0003, 0), 32'h4B80_0002);
        chk32("pin_pos_inf", model(65536, 120), 32'h7F80_0000);
        chk32("pin_neg_inf", model(-65536, 120), 32'hFF80_0000);
        chk32("pin_underflow", model(1, -160), 32'h0);
        chk_int("pin_lat_one", lat(65536, 18), 4);
        chk_int("pin_lat_lsb", lat(1, 18), 20);
        chk_int("pin_lat_zero", lat(0, 18), 1);

        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        chk32("rst_a_out", a_out, 32'h0);
        chk1("rst_a_ovld", a_ovld, 1'b0);
        chk1("rst_a_rdy", a_rdy, 1'b1);
        chk1("rst_a_busy", a_busy, 1'b0);
        chk32("rst_b_out", b_out, 32'h0);
        chk1("rst_b_ovld", b_ovld, 1'b0);
        chk1("rst_b_rdy", b_rdy, 1'b1);

        fork
            run_a();
            run_b();
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
